// File: rtl/music_pkg.sv
// Shared types and constants for the buzzer song sequencer.
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LOAD = 3'd2,
    ST_PLAY = 3'd3,
    ST_GAP  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  localparam int unsigned HZ_W  = 5;
  localparam int unsigned PER_W = 20;

  localparam logic [HZ_W-1:0] REST_CODE = 5'd0;
  localparam logic [7:0]      END_MARK  = 8'd0;

  localparam logic [1:0] VOL_MUTE    = 2'd0;
  localparam logic [2:0] VOL_SH_LOW  = 3'd6;
  localparam logic [2:0] VOL_SH_MID  = 3'd5;
  localparam logic [2:0] VOL_SH_HIGH = 3'd4;

  // Code 31 is a high alert chirp; 1..30 walk semitones upward from C5.
  localparam int unsigned BEEP_HZ = 32'd7812;

  function automatic int unsigned note_hz(input int unsigned code);
    int unsigned base;
    if (code == 32'd0) begin
      return 32'd0;
    end else if (code == 32'd31) begin
      return BEEP_HZ;
    end else begin
      case ((code - 32'd1) % 32'd12)
        32'd0:   base = 32'd523;
        32'd1:   base = 32'd554;
        32'd2:   base = 32'd587;
        32'd3:   base = 32'd622;
        32'd4:   base = 32'd659;
        32'd5:   base = 32'd698;
        32'd6:   base = 32'd740;
        32'd7:   base = 32'd784;
        32'd8:   base = 32'd831;
        32'd9:   base = 32'd880;
        32'd10:  base = 32'd932;
        32'd11:  base = 32'd988;
        default: base = 32'd523;
      endcase
      return base << ((code - 32'd1) / 32'd12);
    end
  endfunction

endpackage

// File: rtl/note_cycle_lut.sv
// Pitch code to tone period in clock cycles; code 0 (rest) maps to period 1.
module note_cycle_lut
  import music_pkg::*;
#(
  parameter int unsigned CLK_FRE = 50
) (
  input  logic [HZ_W-1:0]  code_i,
  output logic [PER_W-1:0] period_o
);

  localparam int unsigned CLK_HZ = CLK_FRE * 32'd1000000;

  logic [PER_W-1:0] tab_s [2**HZ_W];

  for (genvar g = 0; g < 2**HZ_W; g++) begin : g_tab
    localparam int unsigned F = note_hz(g);
    localparam int unsigned P = CLK_HZ / ((F == 32'd0) ? CLK_HZ : F);
    assign tab_s[g] = PER_W'(P);
  end

  assign period_o = tab_s[code_i];

endmodule

// File: rtl/music_player.sv
// Multi-song buzzer sequencer: walks an external note ROM and drives an
// active-low PWM buzzer with live volume control and optional looping.
module music_player
  import music_pkg::*;
#(
  parameter int unsigned CLK_FRE  = 50,
  parameter int unsigned TICK_CYC = CLK_FRE * 1000000 / 8,
  parameter int unsigned SONG_W   = 2,
  parameter int unsigned STEP_W   = 7,
  parameter int unsigned GAP_CYC  = CLK_FRE * 1000 * 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic [SONG_W-1:0]        song_sel,
  input  logic                     loop_en,
  input  logic [1:0]               vol,
  output logic [SONG_W+STEP_W-1:0] rom_addr,
  input  logic [HZ_W-1:0]          rom_hz,
  input  logic [7:0]               rom_time,
  output logic                     busy,
  output logic                     done,
  output logic                     buzzer
);

  localparam logic [STEP_W-1:0] STEP_MAX = '1;
  localparam logic [31:0]       GAP_LAST = 32'(GAP_CYC - 1);

  state_e              state_q, state_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [HZ_W-1:0]     hz_q, hz_d;
  logic [31:0]         dur_q, dur_d, dur_cnt_q, dur_cnt_d, gap_cnt_q, gap_cnt_d;
  logic [PER_W-1:0]    hz_cnt_q, hz_cnt_d, period_s, thr_s;
  logic [2:0]          sh_s;
  logic                end_mark_s;
  logic [SONG_W+STEP_W-1:0] rom_addr_q, rom_addr_d;
  logic                busy_q, busy_d, done_q, done_d, buzzer_q, buzzer_d;

  note_cycle_lut #(.CLK_FRE(CLK_FRE)) u_lut (
    .code_i   (hz_q),
    .period_o (period_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      song_q     <= '0;
      step_q     <= '0;
      hz_q       <= '0;
      dur_q      <= '0;
      dur_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      hz_cnt_q   <= '0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      buzzer_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      step_q     <= step_d;
      hz_q       <= hz_d;
      dur_q      <= dur_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      hz_cnt_q   <= hz_cnt_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      buzzer_q   <= buzzer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    song_d     = song_q;
    step_d     = step_q;
    hz_d       = hz_q;
    dur_d      = dur_q;
    dur_cnt_d  = '0;
    gap_cnt_d  = '0;
    end_mark_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          song_d  = song_sel;
          step_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: state_d = ST_LOAD;
      ST_LOAD: begin
        hz_d  = rom_hz;
        dur_d = 32'(rom_time) * TICK_CYC;
        if (rom_time == END_MARK) begin
          end_mark_s = 1'b1;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (dur_cnt_q == dur_q - 32'd1) begin
          state_d = ST_GAP;
        end else begin
          dur_cnt_d = dur_cnt_q + 32'd1;
        end
      end
      ST_GAP: begin
        // The last ROM word of a song acts as an implicit end marker.
        if (gap_cnt_q != GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end else if (step_q == STEP_MAX) begin
          end_mark_s = 1'b1;
        end else begin
          step_d  = step_q + STEP_W'(1);
          state_d = ST_ADDR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (end_mark_s) begin
      if (loop_en) begin
        step_d  = '0;
        state_d = ST_ADDR;
      end else begin
        state_d = ST_DONE;
      end
    end else begin
      state_d = state_d;
    end
    if (stop) begin
      state_d   = ST_IDLE;
      step_d    = '0;
      dur_cnt_d = '0;
      gap_cnt_d = '0;
    end else begin
      state_d = state_d;
    end
  end

  always_comb begin
    case (vol)
      2'd1:    sh_s = VOL_SH_LOW;
      2'd2:    sh_s = VOL_SH_MID;
      default: sh_s = VOL_SH_HIGH;
    endcase
    thr_s = period_s >> sh_s;
    // Tone phase only advances while staying in PLAY, so each note starts at 0.
    if (state_q == ST_PLAY && state_d == ST_PLAY) begin
      hz_cnt_d = (hz_cnt_q == period_s - PER_W'(1)) ? '0 : hz_cnt_q + PER_W'(1);
    end else begin
      hz_cnt_d = '0;
    end
    if (stop || state_q != ST_PLAY || vol == VOL_MUTE || hz_q == REST_CODE) begin
      buzzer_d = 1'b1;
    end else begin
      buzzer_d = !(hz_cnt_q < thr_s);
    end
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    rom_addr_d = {song_d, step_d};
  end

  assign rom_addr = rom_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign buzzer   = buzzer_q;

endmodule
